// File: rtl/fp_add_sequencer.sv
// Sequencer for FP32 add/sub: captures one operand pair, resolves special operands locally, otherwise runs the adder core.
// Latency: special path result two cycles after accept; core path result one cycle after core_done (or after timeout).
// Backpressure: one transaction in flight; in_ready low outside IDLE; result held in DONE until out_ready.
module fp_add_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic        core_start,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_special,
    output logic        out_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] C_ZERO = 3'b000;
    localparam logic [2:0] C_INF  = 3'b001;
    localparam logic [2:0] C_SUB  = 3'b010;
    localparam logic [2:0] C_NORM = 3'b011;
    localparam logic [2:0] C_NAN  = 3'b100;

    localparam logic [31:0] QNAN_POS = 32'h7FC00000;
    localparam logic [31:0] QNAN_NEG = 32'hFFC00000;

    // Timer only needs to reach TIMEOUT_CYCLES-1; keep at least one bit when the timeout is disabled.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    function automatic logic [2:0] classify(input logic [31:0] x);
        logic [2:0] c;
        if (x[30:23] == 8'h00)      c = (x[22:0] == 23'd0) ? C_ZERO : C_SUB;
        else if (x[30:23] == 8'hFF) c = (x[22:0] == 23'd0) ? C_INF : C_NAN;
        else                        c = C_NORM;
        return c;
    endfunction

    // Returns {handled, result}. NaNs propagate quieted (A first); Inf-Inf is the negative default qNaN;
    // zero plus zero follows round-to-nearest sign rules; zero plus finite returns the other operand.
    function automatic logic [32:0] special_cases(input logic [31:0] a, input logic [31:0] b);
        logic [2:0]  ta;
        logic [2:0]  tb;
        logic [32:0] r;
        ta = classify(a);
        tb = classify(b);
        r  = 33'd0;
        if (ta == C_NAN)                       r = {1'b1, a | 32'h00400000};
        else if (tb == C_NAN)                  r = {1'b1, b | 32'h00400000};
        else if (ta == C_INF && tb == C_INF)   r = {1'b1, (a[31] == b[31]) ? a : QNAN_NEG};
        else if (ta == C_INF)                  r = {1'b1, a};
        else if (tb == C_INF)                  r = {1'b1, b};
        else if (ta == C_ZERO && tb == C_ZERO) r = {1'b1, a[31] & b[31], 31'd0};
        else if (ta == C_ZERO)                 r = {1'b1, b};
        else if (tb == C_ZERO)                 r = {1'b1, a};
        return r;
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [31:0]   res_q;
    logic          special_q;
    logic          timeout_q;
    logic [TW-1:0] timer;

    logic          cap_en;
    logic          res_ld;
    logic [31:0]   res_nxt;
    logic          special_nxt;
    logic          timeout_nxt;
    logic          tmr_clr;
    logic          tmr_inc;
    logic [32:0]   sc;
    logic          tmo_hit;

    assign sc      = special_cases(a_q, b_q);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (timer == TMAX);

    assign in_ready    = (state == S_IDLE) && !rst;
    assign core_start  = (state == S_ISSUE);
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign core_a      = a_q;
    assign core_b      = b_q;
    assign out_result  = res_q;
    assign out_special = special_q;
    assign out_timeout = timeout_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath load decisions.
    always_comb begin
        state_nxt   = state;
        cap_en      = 1'b0;
        res_ld      = 1'b0;
        res_nxt     = res_q;
        special_nxt = special_q;
        timeout_nxt = timeout_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    cap_en    = 1'b1;
                    state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (sc[32]) begin
                    res_ld      = 1'b1;
                    res_nxt     = sc[31:0];
                    special_nxt = 1'b1;
                    timeout_nxt = 1'b0;
                    state_nxt   = S_DONE;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_clr   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                tmr_inc = 1'b1;
                if (core_done) begin
                    res_ld      = 1'b1;
                    res_nxt     = core_result;
                    special_nxt = 1'b0;
                    timeout_nxt = 1'b0;
                    state_nxt   = S_DONE;
                end else if (tmo_hit) begin
                    res_ld      = 1'b1;
                    res_nxt     = QNAN_POS;
                    special_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture; B sign is flipped here so the core only ever adds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 32'd0;
            b_q <= 32'd0;
        end else if (cap_en) begin
            a_q <= in_a;
            b_q <= {in_b[31] ^ in_sub, in_b[30:0]};
        end
    end

    // Result and status flags, loaded only on entry to DONE so they stay stable there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q     <= 32'd0;
            special_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (res_ld) begin
            res_q     <= res_nxt;
            special_q <= special_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Wait timer; saturates so it cannot wrap when the timeout is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (tmr_clr) begin
            timer <= '0;
        end else if (tmr_inc && (timer != {TW{1'b1}})) begin
            timer <= timer + TW'(1);
        end
    end

endmodule
